// File: rtl/reg_file.sv
// Two-read / one-write register file with a hard-wired zero row and flip-flop storage.
// Optional build macro REGFILE_BYPASS_EN adds same-cycle write-through forwarding on both read ports.
module reg_file #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     RegWrite,
  input  logic [$clog2(DEPTH)-1:0] WriteRegister,
  input  logic [WIDTH-1:0]         WriteData,
  input  logic [$clog2(DEPTH)-1:0] ReadRegister1,
  input  logic [$clog2(DEPTH)-1:0] ReadRegister2,
  output logic [WIDTH-1:0]         ReadData1,
  output logic [WIDTH-1:0]         ReadData2
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

  logic [DEPTH-1:0] wr_en_d;
  logic [WIDTH-1:0] row_val [DEPTH];

  always_comb begin
    wr_en_d = '0;
    if (RegWrite) wr_en_d[WriteRegister] = 1'b1;
  end

  // The zero row has no flops; every other row is a resettable register.
  for (genvar r = 0; r < DEPTH; r++) begin : g_row
    if (r == ZERO_REG) begin : g_zero
      assign row_val[r] = '0;
    end else begin : g_store
      logic [WIDTH-1:0] row_q;
      always_ff @(posedge clk) begin
        if (reset)           row_q <= '0;
        else if (wr_en_d[r]) row_q <= WriteData;
      end
      assign row_val[r] = row_q;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd1, fwd2;

  always_comb begin
    fwd1 = RegWrite && (WriteRegister == ReadRegister1) && (WriteRegister != ZERO_IDX);
    fwd2 = RegWrite && (WriteRegister == ReadRegister2) && (WriteRegister != ZERO_IDX);
    if (reset) begin
      ReadData1 = '0;
      ReadData2 = '0;
    end else begin
      ReadData1 = fwd1 ? WriteData : row_val[ReadRegister1];
      ReadData2 = fwd2 ? WriteData : row_val[ReadRegister2];
    end
  end
`else
  always_comb begin
    ReadData1 = row_val[ReadRegister1];
    ReadData2 = row_val[ReadRegister2];
  end
`endif

endmodule

// File: doc/reg_file.md
# reg_file

Multi-ported register file for the pipelined 64-bit CPU datapath. It stores architectural registers in synchronous, resettable flip-flop storage, one register per row. It is the read-side counterpart to the bare flip-flop storage element: a decoded write port plus two independent read ports. It sits between instruction decode (register addresses) and the execute stage (operands), with writeback driving the write port.

## Interface
Parameters:
- WIDTH, 64, data width of each register in bits.
- DEPTH, 32, number of registers; must be a power of two.
- ZERO_REG, 31, index hard-wired to read as 0; writes to it are discarded.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  reset, synchronous, active-high; clock clk.
- RegWrite  input  1  write enable for the write port.
- WriteRegister  input  log2(DEPTH)  destination register index.
- WriteData  input  WIDTH  data to write.
- ReadRegister1  input  log2(DEPTH)  read port 1 index.
- ReadRegister2  input  log2(DEPTH)  read port 2 index.
- ReadData1  output  WIDTH  contents of ReadRegister1.
- ReadData2  output  WIDTH  contents of ReadRegister2.

## Operation
- Storage: DEPTH rows × WIDTH bits of edge-triggered flip-flops with synchronous reset.
- Write decoder: one-hot decode of WriteRegister, gated by RegWrite. The selected row loads WriteData on the rising edge. All other rows hold their value.
- Row ZERO_REG: never loads, and always reads as 0. No storage is required for it.
- Read ports: purely combinational DEPTH:1 muxes indexed by ReadRegister1 and ReadRegister2. The two ports are fully independent, and both may address the same row.
- Reset: when reset is high at a rising edge, every row is cleared to 0.
  - Reset has priority over a simultaneous write; the write is lost.
  - Reset asserted mid-sequence clears all rows on that edge, regardless of pending writes.
- Reset values of outputs: ReadData1 = ReadData2 = 0 for any address after the reset edge.
- Out-of-range index (only possible if DEPTH is not a power of two; disallowed): no defined behaviour required.
- Index wrap: none. Indices are exactly log2(DEPTH) bits.

## Timing
- Write latency: 1 cycle. Data is visible on a read port after the rising edge that samples RegWrite=1.
- Read latency: 0 cycles (combinational from ReadRegisterN and stored state).
- Same-cycle read and write of the same index (non-ZERO_REG), without bypass: the read returns the old value until the edge, then the new value.
- RegWrite=0: no row changes, whatever the values of WriteRegister and WriteData.
- No handshake. The write port is single-cycle fire-and-forget, and reads are always valid.

## Configuration
- REGFILE_BYPASS_EN: compiles in write-through forwarding, so that back-to-back writeback/decode needs no stall.
- Defined:
  - A read port returns WriteData combinationally when all three hold: RegWrite=1, WriteRegister equals that port's index, and the index is not ZERO_REG.
  - Reset high suppresses bypass, and the port returns 0.
- Not defined: reads return only stored state, so the same-cycle read-after-write returns the old value.

## Test plan
- Reset → read: assert reset for 1 edge, then read all 32 indices on both ports → every value is 0.
- Write/read: write X5=0x0123_4567_89AB_CDEF, then X12=0xFFFF_FFFF_FFFF_FFFF → next cycle ReadRegister1=5, ReadRegister2=12 return those values; X6 still reads 0.
- Zero register: RegWrite=1, WriteRegister=31, WriteData=0xDEAD → ReadData1 on index 31 is 0 in the same cycle and all later cycles.
- Write disabled: RegWrite=0, WriteRegister=3, WriteData=0x55 → X3 holds its prior value 0x0 after the edge.
- Same-cycle RAW: X7=0xA, then in one cycle write X7=0xB while reading X7 → reads 0xB before the edge with REGFILE_BYPASS_EN defined, 0xA without it; 0xB after the edge in both builds.
- Reset vs write: reset=1 and RegWrite=1 with X9=0x77 on the same edge → X9 reads 0 afterwards; previously written X5 also reads 0.
